dds_phase_adj_slave: RTL and testbench

//  Slave DDS channel: 32-bit phase accumulator plus sine LUT that drives a 16-bit DAC word.

---
 rtl/dds_phase_adj_slave.sv | 190 +++++++++++++++++++
 tb/tb_dds_phase_adj_slave.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_adj_slave.sv
// Slave DDS channel: 32-bit phase accumulator, full-wave sine ROM feeding a 16-bit DAC word,
// and a phase-adjust unit that slews the channel phase offset to an absolute target.
module dds_phase_adj_slave #(
  parameter int LUT_AW = 12,
  parameter int AMPL   = 32767
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               synch,
  input  logic [31:0]        freq,
  input  logic               ph_adj_start,
  input  logic [31:0]        desired_phase,
  input  logic [31:0]        delay_time,
  input  logic [31:0]        work_time,
  output logic               ph_adj_ready,
  output logic               ph_adj_active,
  output logic signed [15:0] dac_signal,
  output logic [31:0]        phase
);

  localparam int LUT_N = 1 << LUT_AW;
  localparam int LUT_Q = LUT_N / 4;

  // Elaboration-time sine: quarter-wave Taylor series, rounded half away from zero.
  function automatic logic signed [15:0] sine_entry(input int k);
    real a, x2, term, sum, v;
    int  quad, j, iv;
    quad = k / LUT_Q;
    j    = k % LUT_Q;
    if (quad == 1 || quad == 3) j = LUT_Q - j;
    a    = 1.5707963267948966 * real'(j) / real'(LUT_Q);
    x2   = a * a;
    term = a;
    sum  = a;
    for (int n = 1; n <= 13; n++) begin
      term = -term * x2 / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    v  = real'(AMPL) * sum;
    iv = $rtoi(v + 0.5);
    if (quad >= 2) iv = -iv;
    return 16'(iv);
  endfunction

  function automatic logic signed [31:0] apply_sign(input logic neg, input logic [31:0] mag);
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  logic signed [15:0] w_lut [LUT_N];
  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam logic signed [15:0] ENTRY = sine_entry(k);
    assign w_lut[k] = ENTRY;
  end

  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_CALC, S_ADJ, S_DONE} state_t;

  state_t             r_state;
  logic [31:0]        r_freq_val;
  logic [31:0]        r_phase;
  logic [31:0]        r_offset;
  logic signed [31:0] r_freq_add;
  logic [LUT_AW-1:0]  r_lut_addr_p1;
  logic signed [15:0] r_dac_p2;
  logic [31:0]        r_cnt;
  logic [31:0]        r_desired;
  logic [31:0]        r_delay;
  logic [31:0]        r_w;
  logic [31:0]        r_quo;
  logic [31:0]        r_rem;
  logic               r_neg;
  logic               r_ready;
  logic               r_active;

  logic [31:0] w_work;
  logic [31:0] w_err;
  logic [31:0] w_mag;
  logic [32:0] w_shift;
  logic        w_fits;
  logic [31:0] w_sub;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;

  assign w_work = (work_time == 32'd0) ? 32'd1 : work_time;
  // Wrapping difference read as signed; 0x80000000 becomes magnitude 2^31, which still fits.
  assign w_err  = r_desired - r_offset;
  assign w_mag  = w_err[31] ? (32'd0 - w_err) : w_err;

  // One restoring-division step: partial remainder shifted left with the next dividend bit.
  assign w_shift    = {r_rem, r_quo[31]};
  assign w_fits     = (w_shift >= {1'b0, r_w});
  assign w_sub      = w_shift[31:0] - r_w;
  assign w_rem_next = w_fits ? w_sub : w_shift[31:0];
  assign w_quo_next = {r_quo[30:0], w_fits};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_freq_val    <= '0;
      r_phase       <= '0;
      r_offset      <= '0;
      r_lut_addr_p1 <= '0;
      r_dac_p2      <= '0;
    end else begin
      if (synch) r_freq_val <= freq;
      r_phase  <= r_phase + r_freq_val + $unsigned(r_freq_add);
      r_offset <= r_offset + $unsigned(r_freq_add);
      // stage p1: ROM address
      r_lut_addr_p1 <= r_phase[31 -: LUT_AW];
      // stage p2: ROM data
      r_dac_p2 <= w_lut[r_lut_addr_p1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_freq_add <= '0;
      r_ready    <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (ph_adj_start) begin
            r_desired <= desired_phase;
            r_delay   <= delay_time;
            r_w       <= w_work;
            r_active  <= 1'b1;
            r_ready   <= 1'b0;
            if (delay_time == 32'd0) begin
              r_state <= S_CALC;
              r_cnt   <= 32'd0;
            end else begin
              r_state <= S_DELAY;
              r_cnt   <= 32'd1;
            end
          end
        end
        S_DELAY: begin
          if (r_cnt == r_delay) begin
            r_state <= S_CALC;
            r_cnt   <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_CALC: begin
          // First clock latches |err|, then 32 clocks of division.
          if (r_cnt == 32'd0) begin
            r_quo <= w_mag;
            r_rem <= 32'd0;
            r_neg <= w_err[31];
            r_cnt <= 32'd1;
          end else begin
            r_quo <= w_quo_next;
            r_rem <= w_rem_next;
            if (r_cnt == 32'd32) begin
              r_state    <= S_ADJ;
              r_cnt      <= 32'd1;
              r_freq_add <= apply_sign(r_neg, (r_w == 32'd1) ? (w_quo_next + w_rem_next)
                                                             : w_quo_next);
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
        end
        S_ADJ: begin
          if (r_cnt == r_w) begin
            r_state    <= S_DONE;
            r_freq_add <= '0;
            r_active   <= 1'b0;
            r_ready    <= 1'b1;
          end else begin
            r_cnt      <= r_cnt + 32'd1;
            r_freq_add <= apply_sign(r_neg, (r_cnt + 32'd1 == r_w) ? (r_quo + r_rem) : r_quo);
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_freq_add <= '0;
        end
      endcase
    end
  end

  assign phase         = r_phase;
  assign dac_signal    = r_dac_p2;
  assign ph_adj_ready  = r_ready;
  assign ph_adj_active = r_active;

endmodule

// File: tb/tb_dds_phase_adj_slave.sv
// Bench for dds_phase_adj_slave: two channels on shared clk/reset/synch/freq; instance 1 never
// adjusts, so phase0 - phase1 exposes instance 0's accumulated offset and per-clock correction.
module tb_dds_phase_adj_slave;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, synch, ph_adj_start;
  logic [31:0] freq, desired_phase, delay_time, work_time;
  logic        rdy0, act0, rdy1, act1;
  logic [15:0] dac0, dac1;
  logic [31:0] ph0, ph1;

  dds_phase_adj_slave u0 (
    .clk(clk), .reset(reset), .synch(synch), .freq(freq),
    .ph_adj_start(ph_adj_start), .desired_phase(desired_phase),
    .delay_time(delay_time), .work_time(work_time),
    .ph_adj_ready(rdy0), .ph_adj_active(act0), .dac_signal(dac0), .phase(ph0)
  );

  dds_phase_adj_slave u1 (
    .clk(clk), .reset(reset), .synch(synch), .freq(freq),
    .ph_adj_start(1'b0), .desired_phase(desired_phase),
    .delay_time(delay_time), .work_time(work_time),
    .ph_adj_ready(rdy1), .ph_adj_active(act1), .dac_signal(dac1), .phase(ph1)
  );

  typedef struct { int clocks; logic [15:0] exp_hi; } hi_vec_t;
  typedef struct { int idx; logic [15:0] exp_dac; } dac_vec_t;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_off;
  logic [31:0] fd, ld;
  hi_vec_t     hi_tab [4];
  dac_vec_t    dac_tab [7];
  dac_vec_t    sb_q [$];
  dac_vec_t    e, p;
  logic [31:0] model_ph;
  int          ph_errs;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_off = 32'd0;
  endtask

  function automatic logic [15:0] sine_model(input int k);
    real v;
    int  iv;
    v = 32767.0 * $sin(6.283185307179586 * real'(k) / 4096.0);
    if (v >= 0.0) iv = $rtoi(v + 0.5);
    else iv = -$rtoi(0.5 - v);
    return iv[15:0];
  endfunction

  // Runs one adjustment on u0 from the modelled offset and checks per-clock correction,
  // ready/active timing and the final offset. inj_k > 0 pulses start+synch at that clock.
  task automatic run_adj(input string nm, input logic [31:0] des, input logic [31:0] dly,
                         input logic [31:0] wrk, input int inj_k, input logic [31:0] inj_freq,
                         output logic [31:0] first_d, output logic [31:0] last_d);
    logic [31:0] w, err, mag, q, r, step, last_step, prev, diff, exp_d;
    logic        neg;
    int          ready_at, rdy_k, d_errs, a_errs;
    w         = (wrk == 32'd0) ? 32'd1 : wrk;
    err       = des - exp_off;
    neg       = err[31];
    mag       = neg ? (32'd0 - err) : err;
    q         = mag / w;
    r         = mag % w;
    step      = neg ? (32'd0 - q) : q;
    last_step = neg ? (32'd0 - (q + r)) : (q + r);
    ready_at  = int'(dly) + 33 + int'(w);
    first_d = 32'd0; last_d = 32'd0; rdy_k = -1; d_errs = 0; a_errs = 0;
    desired_phase = des; delay_time = dly; work_time = wrk; ph_adj_start = 1'b1;
    tick();
    ph_adj_start = 1'b0;
    check($sformatf("%s accept active", nm), {31'd0, act0}, 32'd1);
    check($sformatf("%s accept ready", nm), {31'd0, rdy0}, 32'd0);
    prev = ph0 - ph1;
    for (int k = 1; k <= ready_at + 3; k++) begin
      if (k == inj_k) begin
        ph_adj_start = 1'b1; desired_phase = 32'h11111111; delay_time = 32'd7;
        work_time = 32'd3; synch = 1'b1; freq = inj_freq;
      end
      tick();
      if (k == inj_k) begin
        ph_adj_start = 1'b0; synch = 1'b0;
      end
      diff = ph0 - ph1;
      if (k == ready_at) exp_d = last_step;
      else if (k >= int'(dly) + 34 && k < ready_at) exp_d = step;
      else exp_d = 32'd0;
      if ((diff - prev) !== exp_d) d_errs++;
      if (k == int'(dly) + 34) first_d = diff - prev;
      if (k == ready_at) last_d = diff - prev;
      if (act0 !== (k < ready_at)) a_errs++;
      if (rdy0 === 1'b1 && rdy_k < 0) rdy_k = k;
      prev = diff;
    end
    check($sformatf("%s correction steps wrong", nm), d_errs, 0);
    check($sformatf("%s active profile wrong", nm), a_errs, 0);
    check($sformatf("%s ready clock", nm), rdy_k, ready_at);
    check($sformatf("%s ready held", nm), {31'd0, rdy0}, 32'd1);
    check($sformatf("%s final offset", nm), ph0 - ph1, des);
    exp_off = des;
  endtask

  initial begin
    hi_tab[0] = '{1, 16'h0147};
    hi_tab[1] = '{1, 16'h028F};
    hi_tab[2] = '{1, 16'h03D7};
    hi_tab[3] = '{1, 16'h051E};
    dac_tab[0] = '{20,   16'h03ED};
    dac_tab[1] = '{40,   16'h07D9};
    dac_tab[2] = '{512,  16'h5A82};
    dac_tab[3] = '{1024, 16'h7FFF};
    dac_tab[4] = '{2048, 16'h0000};
    dac_tab[5] = '{2560, 16'hA57E};
    dac_tab[6] = '{3072, 16'h8001};

    reset = 1'b1; synch = 1'b0; freq = 32'd0; ph_adj_start = 1'b0;
    desired_phase = 32'd0; delay_time = 32'd0; work_time = 32'd0; exp_off = 32'd0;
    tick();
    tick();
    check("reset phase", ph0, 32'd0);
    check("reset dac", {16'd0, dac0}, 32'd0);
    check("reset ready", {31'd0, rdy0}, 32'd0);
    check("reset active", {31'd0, act0}, 32'd0);
    reset = 1'b0;

    freq = 32'h0147AEB8; synch = 1'b1;
    tick();
    synch = 1'b0;
    check("freq load latency", ph0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      repeat (hi_tab[i].clocks) tick();
      check($sformatf("phase hi step %0d", i + 1), {16'd0, ph0[31:16]}, {16'd0, hi_tab[i].exp_hi});
    end

    do_reset();
    freq = 32'h00100000; synch = 1'b1;
    tick();
    synch = 1'b0;
    model_ph = 32'd0; ph_errs = 0; sb_q.delete();
    for (int n = 0; n < 4096 + 8; n++) begin
      e.idx = int'(model_ph[31:20]);
      e.exp_dac = sine_model(e.idx);
      sb_q.push_back(e);
      if (ph0 !== model_ph) ph_errs++;
      if (sb_q.size() == 3) begin
        p = sb_q.pop_front();
        check($sformatf("dac idx %0d", p.idx), {16'd0, dac0}, {16'd0, p.exp_dac});
        for (int j = 0; j < 7; j++)
          if (dac_tab[j].idx == p.idx)
            check($sformatf("dac table idx %0d", p.idx), {16'd0, dac0}, {16'd0, dac_tab[j].exp_dac});
      end
      tick();
      model_ph = model_ph + 32'h00100000;
    end
    check("sweep phase errors", ph_errs, 0);

    freq = 32'h0147AEB8; synch = 1'b1;
    tick();
    synch = 1'b0;
    run_adj("half turn", 32'h80000000, 32'd0, 32'd2000, 0, 32'd0, fd, ld);
    check("half turn first step", fd, 32'(-1073741));
    check("half turn last step", ld, 32'(-1075389));
    repeat (10) tick();
    check("half turn hold", ph0 - ph1, 32'h80000000);

    run_adj("small positive", 32'h80001000, 32'd2, 32'd7, 0, 32'd0, fd, ld);
    check("small positive first step", fd, 32'd585);
    check("small positive last step", ld, 32'd586);

    run_adj("zero err", 32'h80001000, 32'd0, 32'd5, 0, 32'd0, fd, ld);

    run_adj("busy start", 32'h40000000, 32'd5, 32'd300, 200, 32'h00A00000, fd, ld);

    do_reset();
    run_adj("work zero", 32'hFF000000, 32'd10, 32'd0, 0, 32'd0, fd, ld);
    check("work zero single step", ld, 32'hFF000000);

    desired_phase = 32'h20000000; delay_time = 32'd0; work_time = 32'd100; ph_adj_start = 1'b1;
    tick();
    ph_adj_start = 1'b0;
    repeat (53) tick();
    check("mid adj active", {31'd0, act0}, 32'd1);
    check("mid adj moved", {31'd0, (ph0 - ph1) != 32'hFF000000}, 32'd1);
    reset = 1'b1;
    tick();
    check("abort active", {31'd0, act0}, 32'd0);
    check("abort ready", {31'd0, rdy0}, 32'd0);
    check("abort phase0", ph0, 32'd0);
    check("abort phase1", ph1, 32'd0);
    reset = 1'b0;
    exp_off = 32'd0;
    freq = 32'h00100000; synch = 1'b1;
    tick();
    synch = 1'b0;
    repeat (5) tick();
    check("abort no residual correction", ph0 - ph1, 32'd0);
    check("abort stays idle", {31'd0, act0}, 32'd0);
    run_adj("after abort", 32'h12345678, 32'd3, 32'd50, 0, 32'd0, fd, ld);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
